// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the RAM word port of the main-RAM arbiter.
// The arbiter uses the slave view; the requesters and RAM array use the master view.
interface mem_port_arbiter_if #(
   parameter int IDX_W = 16
);
   logic             cpu_req;
   logic             cpu_we;
   logic [31:0]      cpu_addr;
   logic [3:0]       cpu_be;
   logic [31:0]      cpu_wdata;
   logic             cpu_gnt;
   logic             cpu_rvalid;
   logic [31:0]      cpu_rdata;

   logic             dma_req;
   logic             dma_we;
   logic [31:0]      dma_addr;
   logic [3:0]       dma_be;
   logic [31:0]      dma_wdata;
   logic             dma_last;
   logic             dma_gnt;
   logic             dma_rvalid;
   logic [31:0]      dma_rdata;

   logic             ram_en;
   logic             ram_we;
   logic [IDX_W-1:0] ram_idx;
   logic [3:0]       ram_be;
   logic [31:0]      ram_wdata;
   logic [31:0]      ram_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_be, dma_wdata, dma_last,
      output dma_gnt, dma_rvalid, dma_rdata,
      output ram_en, ram_we, ram_idx, ram_be, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_be, dma_wdata, dma_last,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  ram_en, ram_we, ram_idx, ram_be, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported main RAM between the CPU memory stage and the DMA engine,
// with starvation-based priority, locked DMA bursts and a one-cycle read return path.
module mem_port_arbiter #(
   parameter int RAM_WORDS    = 33750,
   parameter int IDX_W        = 16,
   parameter int BURST_MAX    = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   mem_port_arbiter_if.slave   bus,
   output logic                o_owner,
   output logic                o_busy
);
   localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam int BEAT_W = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0]  WAIT_MAX  = CNT_W'(STARVE_LIMIT);
   localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(BURST_MAX);
   localparam logic [IDX_W:0]    RAM_LIMIT = (IDX_W + 1)'(RAM_WORDS);

   typedef enum logic {IDLE, DMA_BURST} state_t;

   state_t            r_state, w_stateNext;
   logic [BEAT_W-1:0] r_beatCnt, w_beatCntNext;
   logic [CNT_W-1:0]  r_cpuWait, r_dmaWait, w_cpuWaitNext, w_dmaWaitNext;
   logic              r_rdPend, r_rdDma, r_rdInRange, r_owner;

   logic              w_cpuGnt, w_dmaGnt, w_accept, w_we, w_inRange;
   logic [IDX_W-1:0]  w_idx;
   logic              w_unusedAddrBits;

   assign w_unusedAddrBits = ^{bus.cpu_addr[31:IDX_W+2], bus.cpu_addr[1:0],
                               bus.dma_addr[31:IDX_W+2], bus.dma_addr[1:0]};

   // Grants are gated by reset so nothing can be accepted while the block is held in reset.
   always_comb begin
      w_cpuGnt      = 1'b0;
      w_dmaGnt      = 1'b0;
      w_stateNext   = r_state;
      w_beatCntNext = r_beatCnt;
      if (i_rst_n) begin
         case (r_state)
            IDLE: begin
               w_cpuGnt = bus.cpu_req && (r_dmaWait < WAIT_MAX);
               w_dmaGnt = bus.dma_req && !w_cpuGnt;
            end
            DMA_BURST: w_dmaGnt = bus.dma_req;
            default: ;
         endcase
      end

      if (w_dmaGnt) begin
         w_beatCntNext = (r_state == IDLE) ? BEAT_W'(1) : r_beatCnt + BEAT_W'(1);
         w_stateNext   = (bus.dma_last || w_beatCntNext == BEAT_MAX) ? IDLE : DMA_BURST;
      end

      w_cpuWaitNext = '0;
      if (bus.cpu_req && !w_cpuGnt)
         w_cpuWaitNext = (r_cpuWait == WAIT_MAX) ? WAIT_MAX : r_cpuWait + CNT_W'(1);
      w_dmaWaitNext = '0;
      if (bus.dma_req && !w_dmaGnt)
         w_dmaWaitNext = (r_dmaWait == WAIT_MAX) ? WAIT_MAX : r_dmaWait + CNT_W'(1);

      // A starving CPU breaks the DMA lock; the DMA simply re-arbitrates from IDLE.
      if (w_cpuWaitNext == WAIT_MAX)
         w_stateNext = IDLE;
   end

   always_comb begin
      w_accept  = w_cpuGnt || w_dmaGnt;
      w_we      = w_dmaGnt ? bus.dma_we : bus.cpu_we;
      w_idx     = w_dmaGnt ? bus.dma_addr[IDX_W+1:2] : bus.cpu_addr[IDX_W+1:2];
      w_inRange = {1'b0, w_idx} < RAM_LIMIT;

      bus.ram_en    = w_accept && w_inRange;
      bus.ram_we    = w_accept && w_inRange && w_we;
      bus.ram_idx   = w_accept ? w_idx : '0;
      bus.ram_be    = !w_accept ? 4'h0  : (w_dmaGnt ? bus.dma_be    : bus.cpu_be);
      bus.ram_wdata = !w_accept ? 32'h0 : (w_dmaGnt ? bus.dma_wdata : bus.cpu_wdata);

      bus.cpu_gnt = w_cpuGnt;
      bus.dma_gnt = w_dmaGnt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_beatCnt   <= '0;
         r_cpuWait   <= '0;
         r_dmaWait   <= '0;
         r_rdPend    <= 1'b0;
         r_rdDma     <= 1'b0;
         r_rdInRange <= 1'b0;
         r_owner     <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_beatCnt   <= w_beatCntNext;
         r_cpuWait   <= w_cpuWaitNext;
         r_dmaWait   <= w_dmaWaitNext;
         r_rdPend    <= w_accept && !w_we;
         r_rdDma     <= w_dmaGnt;
         r_rdInRange <= w_inRange;
         if (w_accept)
            r_owner <= w_dmaGnt;
      end
   end

   // Out-of-range reads never touched the RAM, so their return data is forced to zero.
   always_comb begin
      bus.cpu_rvalid = r_rdPend && !r_rdDma;
      bus.dma_rvalid = r_rdPend && r_rdDma;
      bus.cpu_rdata  = (bus.cpu_rvalid && r_rdInRange) ? bus.ram_rdata : 32'h0;
      bus.dma_rdata  = (bus.dma_rvalid && r_rdInRange) ? bus.ram_rdata : 32'h0;
   end

   assign o_owner = r_owner;
   assign o_busy  = (r_state == DMA_BURST);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a RAM array, a transaction-level reference model with a
// shadow memory checked every cycle, and directed scenarios with literal expectations.
module tb_mem_port_arbiter;
   localparam int RAM_WORDS    = 33750;
   localparam int IDX_W        = 16;
   localparam int BURST_MAX    = 16;
   localparam int STARVE_LIMIT = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic owner, busy;

   mem_port_arbiter_if #(.IDX_W(IDX_W)) ifc ();

   mem_port_arbiter #(
      .RAM_WORDS(RAM_WORDS), .IDX_W(IDX_W), .BURST_MAX(BURST_MAX), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(ifc), .o_owner(owner), .o_busy(busy)
   );

   always #5 clk = ~clk;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [31:0] ramArray [RAM_WORDS];
   logic [31:0] shadow   [RAM_WORDS];
   int          ramWrites = 0;

   int   dmaWaitsAt [32];
   logic busyAt     [32];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // RAM array with registered reads and byte-enable writes.
   always @(posedge clk) begin
      if (ifc.ram_en) begin
         if (ifc.ram_we) begin
            for (int b = 0; b < 4; b++)
               if (ifc.ram_be[b]) ramArray[ifc.ram_idx][8*b +: 8] <= ifc.ram_wdata[8*b +: 8];
            ramWrites <= ramWrites + 1;
         end else begin
            ifc.ram_rdata <= ramArray[ifc.ram_idx];
         end
      end
   end

   // Reference model: arbitration rules on plain integers plus a shadow copy of RAM contents.
   bit          mBurst, mPend, mPendDma, mOwner;
   int          mBeats, mCpuWait, mDmaWait;
   logic [31:0] mPendData;

   always @(negedge clk) begin : refModel
      bit cpuG, dmaG, acc, we, inRange, last;
      int idx, beats, nCpuW, nDmaW;
      logic [31:0] addr, wd;
      logic [3:0]  be;
      if (!rst_n) begin
         checkOutput("rst_cpu_gnt", ifc.cpu_gnt, 0);
         checkOutput("rst_dma_gnt", ifc.dma_gnt, 0);
         checkOutput("rst_ram_en", ifc.ram_en, 0);
         checkOutput("rst_cpu_rvalid", ifc.cpu_rvalid, 0);
         checkOutput("rst_dma_rvalid", ifc.dma_rvalid, 0);
         checkOutput("rst_owner", owner, 0);
         checkOutput("rst_busy", busy, 0);
         mBurst = 0; mBeats = 0; mCpuWait = 0; mDmaWait = 0;
         mPend = 0; mPendDma = 0; mPendData = 0; mOwner = 0;
      end else begin
         cpuG = !mBurst && ifc.cpu_req && (mDmaWait < STARVE_LIMIT);
         dmaG = ifc.dma_req && (mBurst || !cpuG);
         acc  = cpuG || dmaG;
         addr = dmaG ? ifc.dma_addr  : ifc.cpu_addr;
         we   = dmaG ? ifc.dma_we    : ifc.cpu_we;
         be   = dmaG ? ifc.dma_be    : ifc.cpu_be;
         wd   = dmaG ? ifc.dma_wdata : ifc.cpu_wdata;
         last = ifc.dma_last;
         idx  = int'(addr / 4) % (1 << IDX_W);
         inRange = idx < RAM_WORDS;

         checkOutput("cpu_gnt", ifc.cpu_gnt, cpuG);
         checkOutput("dma_gnt", ifc.dma_gnt, dmaG);
         checkOutput("ram_en", ifc.ram_en, acc && inRange);
         if (acc && inRange) begin
            checkOutput("ram_idx", ifc.ram_idx, idx);
            checkOutput("ram_we", ifc.ram_we, we);
            if (we) begin
               checkOutput("ram_be", ifc.ram_be, be);
               checkOutput("ram_wdata", ifc.ram_wdata, wd);
            end
         end
         checkOutput("cpu_rvalid", ifc.cpu_rvalid, mPend && !mPendDma);
         checkOutput("dma_rvalid", ifc.dma_rvalid, mPend && mPendDma);
         checkOutput("cpu_rdata", ifc.cpu_rdata, (mPend && !mPendDma) ? mPendData : 32'h0);
         checkOutput("dma_rdata", ifc.dma_rdata, (mPend && mPendDma) ? mPendData : 32'h0);
         checkOutput("busy", busy, mBurst);
         checkOutput("owner", owner, mOwner);

         mPend = acc && !we;
         mPendDma = dmaG;
         mPendData = (acc && !we && inRange) ? shadow[idx] : 32'h0;
         if (acc && we && inRange)
            for (int b = 0; b < 4; b++)
               if (be[b]) shadow[idx][8*b +: 8] = wd[8*b +: 8];
         if (acc) mOwner = dmaG;

         nCpuW = (ifc.cpu_req && !cpuG) ? ((mCpuWait >= STARVE_LIMIT) ? STARVE_LIMIT : mCpuWait + 1) : 0;
         nDmaW = (ifc.dma_req && !dmaG) ? ((mDmaWait >= STARVE_LIMIT) ? STARVE_LIMIT : mDmaWait + 1) : 0;
         if (dmaG) begin
            beats  = mBurst ? mBeats + 1 : 1;
            mBeats = beats;
            mBurst = !last && (beats < BURST_MAX);
         end
         if (nCpuW >= STARVE_LIMIT) mBurst = 0;
         mCpuWait = nCpuW;
         mDmaWait = nDmaW;
      end
   end

   // One beat from either requester; called and returns just after a rising edge.
   task automatic applyStimulus(input bit isDma, input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic last, output int waits,
                                output logic [15:0] idxSeen, output logic enSeen, output logic busySeen);
      logic gnt;
      waits = 0;
      gnt = 1'b0;
      if (isDma) begin
         ifc.dma_req = 1; ifc.dma_we = we; ifc.dma_addr = addr;
         ifc.dma_be = 4'hF; ifc.dma_wdata = wd; ifc.dma_last = last;
      end else begin
         ifc.cpu_req = 1; ifc.cpu_we = we; ifc.cpu_addr = addr;
         ifc.cpu_be = 4'hF; ifc.cpu_wdata = wd;
      end
      do begin
         @(negedge clk);
         waits++;
         gnt = isDma ? ifc.dma_gnt : ifc.cpu_gnt;
      end while (!gnt && waits < 64);
      idxSeen  = ifc.ram_idx;
      enSeen   = ifc.ram_en;
      busySeen = busy;
      if (isDma) checkOutput("dma_grant", gnt, 1);
      else       checkOutput("cpu_grant", gnt, 1);
      @(posedge clk); #1;
      if (isDma) begin
         ifc.dma_req = 0; ifc.dma_last = 0;
      end else begin
         ifc.cpu_req = 0;
      end
   endtask

   task automatic dmaBurst(input int n, input logic we, input logic [31:0] base, input logic [31:0] dataBase);
      int w;
      logic [15:0] i;
      logic e, b;
      for (int k = 0; k < n; k++) begin
         applyStimulus(1, we, base + 32'(4 * k), dataBase + 32'(k), (k == n - 1), w, i, e, b);
         dmaWaitsAt[k] = w;
         busyAt[k] = b;
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before 100000ns");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int w, writesBefore;
      logic [15:0] i;
      logic e, b;
      int cpuWaits [6];

      rst_n = 1'b0;
      ifc.cpu_req = 0; ifc.cpu_we = 0; ifc.cpu_addr = 0; ifc.cpu_be = 0; ifc.cpu_wdata = 0;
      ifc.dma_req = 0; ifc.dma_we = 0; ifc.dma_addr = 0; ifc.dma_be = 0; ifc.dma_wdata = 0;
      ifc.dma_last = 0;
      for (int k = 0; k < RAM_WORDS; k++) begin
         ramArray[k] = 32'h1000_0000 + 32'(k * 3);
         shadow[k]   = 32'h1000_0000 + 32'(k * 3);
      end
      ramArray[4] = 32'hDEAD_BEEF;
      shadow[4]   = 32'hDEAD_BEEF;

      // Reset with a CPU request already pending, then a CPU read of word 4.
      @(posedge clk); #1;
      ifc.cpu_req = 1; ifc.cpu_addr = 32'h10; ifc.cpu_we = 0;
      @(negedge clk);
      checkOutput("reset_cpu_gnt", ifc.cpu_gnt, 0);
      checkOutput("reset_ram_en", ifc.ram_en, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      applyStimulus(0, 0, 32'h10, 0, 0, w, i, e, b);
      checkOutput("first_grant_wait", w, 1);
      checkOutput("cpu_read_idx", i, 4);
      checkOutput("cpu_read_en", e, 1);
      @(negedge clk);
      checkOutput("cpu_read_rvalid", ifc.cpu_rvalid, 1);
      checkOutput("cpu_read_rdata", ifc.cpu_rdata, 32'hDEAD_BEEF);
      checkOutput("cpu_read_dma_rvalid", ifc.dma_rvalid, 0);
      @(posedge clk); #1;

      // Simultaneous requests: CPU first, DMA forced in after four waits.
      fork
         begin
            int cw;
            logic [15:0] ci;
            logic ce, cb;
            for (int k = 0; k < 6; k++) begin
               applyStimulus(0, 0, 32'h20 + 32'(4 * k), 0, 0, cw, ci, ce, cb);
               cpuWaits[k] = cw;
            end
         end
         dmaBurst(1, 0, 32'h80, 0);
      join
      checkOutput("dma_starve_wait", dmaWaitsAt[0], 5);
      checkOutput("cpu_first_wait", cpuWaits[0], 1);
      checkOutput("cpu_after_dma_wait", cpuWaits[4], 2);

      // Three-beat write burst with a CPU read arriving on beat 2.
      fork
         dmaBurst(3, 1, 32'h100, 32'hA000_0000);
         begin
            @(posedge clk); #1;
            applyStimulus(0, 0, 32'h104, 0, 0, w, i, e, b);
         end
      join
      checkOutput("burst_cpu_wait", w, 3);
      checkOutput("burst_busy_beat1", busyAt[0], 0);
      checkOutput("burst_busy_beat2", busyAt[1], 1);
      checkOutput("burst_busy_beat3", busyAt[2], 1);
      checkOutput("burst_word64", ramArray[64], 32'hA000_0000);
      checkOutput("burst_word65", ramArray[65], 32'hA000_0001);
      checkOutput("burst_word66", ramArray[66], 32'hA000_0002);
      @(negedge clk);
      checkOutput("burst_cpu_rdata", ifc.cpu_rdata, 32'hA000_0001);
      checkOutput("burst_end_busy", busy, 0);
      @(posedge clk); #1;

      // Twenty-beat burst preempted by a CPU request starting on beat 2.
      fork
         dmaBurst(20, 1, 32'h200, 32'hB000_0000);
         begin
            @(posedge clk); #1;
            applyStimulus(0, 0, 32'h40, 0, 0, w, i, e, b);
         end
      join
      checkOutput("preempt_cpu_wait", w, 5);
      checkOutput("preempt_busy_beat5", busyAt[4], 1);
      checkOutput("preempt_busy_beat6", busyAt[5], 0);
      checkOutput("preempt_dma_wait_beat6", dmaWaitsAt[5], 2);
      checkOutput("preempt_last_word", ramArray[147], 32'hB000_0013);

      // Twenty-beat read burst with no competition: forced release after sixteen beats.
      dmaBurst(20, 0, 32'h300, 0);
      checkOutput("force_busy_beat16", busyAt[15], 1);
      checkOutput("force_busy_beat17", busyAt[16], 0);
      checkOutput("force_busy_beat18", busyAt[17], 1);
      checkOutput("force_wait_beat17", dmaWaitsAt[16], 1);

      // Out-of-range read and write at the first index past the RAM.
      applyStimulus(0, 0, 32'd135000, 0, 0, w, i, e, b);
      checkOutput("oor_read_en", e, 0);
      @(negedge clk);
      checkOutput("oor_read_rvalid", ifc.cpu_rvalid, 1);
      checkOutput("oor_read_rdata", ifc.cpu_rdata, 0);
      @(posedge clk); #1;
      writesBefore = ramWrites;
      applyStimulus(0, 1, 32'd135000, 32'h1234_5678, 0, w, i, e, b);
      checkOutput("oor_write_en", e, 0);
      @(negedge clk);
      checkOutput("oor_write_count", ramWrites - writesBefore, 0);
      checkOutput("oor_write_rvalid", ifc.cpu_rvalid, 0);
      @(posedge clk); #1;

      // Reset mid-burst with a DMA read in flight, CPU request held through reset.
      ifc.dma_req = 1; ifc.dma_we = 0; ifc.dma_addr = 32'h400; ifc.dma_be = 4'hF; ifc.dma_last = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      ifc.dma_req = 0;
      ifc.cpu_req = 1; ifc.cpu_we = 0; ifc.cpu_addr = 32'h10;
      @(negedge clk);
      checkOutput("midrst_dma_rvalid", ifc.dma_rvalid, 0);
      checkOutput("midrst_dma_rdata", ifc.dma_rdata, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_cpu_gnt", ifc.cpu_gnt, 0);
      checkOutput("midrst_ram_en", ifc.ram_en, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      applyStimulus(0, 0, 32'h10, 0, 0, w, i, e, b);
      checkOutput("postrst_grant_wait", w, 1);
      @(negedge clk);
      checkOutput("postrst_dma_rvalid", ifc.dma_rvalid, 0);
      checkOutput("postrst_cpu_rdata", ifc.cpu_rdata, 32'hDEAD_BEEF);
      checkOutput("postrst_busy", busy, 0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
